// File: rtl/weight_server.sv
// weight_server: stores both MLP layer weight matrices in synchronous RAM,
// streams them out one row per cycle on request, and applies saturating
// per-lane delta rows on update requests.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   get_weights0/1            pulse: start layer-0 / layer-1 read stream
//   update0/1                 pulse: start layer-0 / layer-1 update stream
//   wchange0/1                delta row sampled each update-stream cycle
//   init_we/layer/addr/data   host row write, accepted only while idle
//   weights0/1, w0/w1_valid   streamed row and its qualifier (0 when idle)
//   busy                      any stream active
module weight_server #(
  parameter int unsigned NUM_NEURONS = 128,
  parameter int unsigned IMG_SZ      = 784,
  parameter int unsigned OUTPUT_SZ   = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               get_weights0,
  input  logic                               get_weights1,
  input  logic                               update0,
  input  logic                               update1,
  input  logic [NUM_NEURONS-1:0][31:0]       wchange0,
  input  logic [OUTPUT_SZ-1:0][31:0]         wchange1,
  input  logic                               init_we,
  input  logic                               init_layer,
  input  logic [$clog2(IMG_SZ)-1:0]          init_addr,
  input  logic [NUM_NEURONS-1:0][31:0]       init_data,
  output logic [NUM_NEURONS-1:0][31:0]       weights0,
  output logic [OUTPUT_SZ-1:0][31:0]         weights1,
  output logic                               w0_valid,
  output logic                               w1_valid,
  output logic                               busy
);

  localparam int unsigned A0W = $clog2(IMG_SZ);
  localparam int unsigned A1W = $clog2(NUM_NEURONS);
  localparam int unsigned NS  = 4;

  // Stream indices; odd indices belong to layer 1.
  localparam logic [1:0] RD0 = 2'd0;
  localparam logic [1:0] RD1 = 2'd1;
  localparam logic [1:0] UP0 = 2'd2;
  localparam logic [1:0] UP1 = 2'd3;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [A0W-1:0] LAST0 = A0W'(IMG_SZ - 1);
  localparam logic [A0W-1:0] LAST1 = A0W'(NUM_NEURONS - 1);

  typedef logic [NUM_NEURONS-1:0][31:0] row0_t;
  typedef logic [OUTPUT_SZ-1:0][31:0]   row1_t;

  row0_t mem0 [IMG_SZ];
  row1_t mem1 [NUM_NEURONS];

  logic [NS-1:0]  start_c;
  logic [NS-1:0]  act_d_c;
  logic [0:0]     state_q [NS];
  logic [0:0]     state_d [NS];
  logic [A0W-1:0] cnt_q   [NS];
  logic [A0W-1:0] cnt_d   [NS];

  row0_t weights0_q, up0_rdata_q, fwd0_data_q, up0_base_c, up0_new_c;
  row1_t weights1_q, up1_rdata_q, fwd1_data_q, up1_base_c, up1_new_c;
  logic           w0_valid_q, w1_valid_q, busy_q;
  logic           fwd0_v_q, fwd1_v_q;
  logic [A0W-1:0] fwd0_addr_q;
  logic [A1W-1:0] fwd1_addr_q;
  logic           init0_c, init1_c;

  // Signed 32-bit add clamped to the representable range.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31])) return a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    return s;
  endfunction

  assign start_c = {update1, update0, get_weights1, get_weights0};

  // Per-stream next state: a pulse always (re)starts at row 0.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (start_c[i]) begin
        state_d[i] = ACTIVE;
        cnt_d[i]   = '0;
      end else if (state_q[i] == ACTIVE) begin
        if (cnt_q[i] == (i[0] ? LAST1 : LAST0)) begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + A0W'(1);
        end
      end
      act_d_c[i] = (state_d[i] == ACTIVE);
    end
  end

  // Stream state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Update operand: forward the row written last cycle if it is hit again
  // (only possible right after a restart), since the RAM read missed it.
  always_comb begin
    up0_base_c = (fwd0_v_q && (fwd0_addr_q == cnt_q[UP0])) ? fwd0_data_q : up0_rdata_q;
    up1_base_c = (fwd1_v_q && (fwd1_addr_q == cnt_q[UP1][A1W-1:0])) ? fwd1_data_q : up1_rdata_q;
    for (int j = 0; j < NUM_NEURONS; j++) up0_new_c[j] = sat_add(up0_base_c[j], wchange0[j]);
    for (int j = 0; j < OUTPUT_SZ; j++)   up1_new_c[j] = sat_add(up1_base_c[j], wchange1[j]);
  end

  assign init0_c = init_we & ~busy_q & ~init_layer & (32'(init_addr) < IMG_SZ);
  assign init1_c = init_we & ~busy_q &  init_layer & (32'(init_addr) < NUM_NEURONS);

  // Read-stream output rows (RAM read registers, zeroed while idle) and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weights0_q <= '0;
      weights1_q <= '0;
      w0_valid_q <= 1'b0;
      w1_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      fwd0_v_q   <= 1'b0;
      fwd1_v_q   <= 1'b0;
    end else begin
      weights0_q <= act_d_c[RD0] ? mem0[cnt_d[RD0]] : '0;
      weights1_q <= act_d_c[RD1] ? mem1[cnt_d[RD1][A1W-1:0]] : '0;
      w0_valid_q <= act_d_c[RD0];
      w1_valid_q <= act_d_c[RD1];
      busy_q     <= |act_d_c;
      fwd0_v_q   <= (state_q[UP0] == ACTIVE);
      fwd1_v_q   <= (state_q[UP1] == ACTIVE);
    end
  end

  // RAM writes and the update read-ahead (row k fetched one cycle early).
  always_ff @(posedge clk) begin
    up0_rdata_q <= mem0[cnt_d[UP0]];
    up1_rdata_q <= mem1[cnt_d[UP1][A1W-1:0]];
    fwd0_addr_q <= cnt_q[UP0];
    fwd1_addr_q <= cnt_q[UP1][A1W-1:0];
    fwd0_data_q <= up0_new_c;
    fwd1_data_q <= up1_new_c;
    if (state_q[UP0] == ACTIVE) mem0[cnt_q[UP0]] <= up0_new_c;
    else if (init0_c)           mem0[init_addr] <= init_data;
    if (state_q[UP1] == ACTIVE) mem1[cnt_q[UP1][A1W-1:0]] <= up1_new_c;
    else if (init1_c)           mem1[init_addr[A1W-1:0]] <= init_data[OUTPUT_SZ-1:0];
  end

  assign weights0 = weights0_q;
  assign weights1 = weights1_q;
  assign w0_valid = w0_valid_q;
  assign w1_valid = w1_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_weight_server.sv
// Self-checking bench for weight_server: table-driven saturation vectors,
// hand-written multi-cycle sequences, and randomized updates checked against
// a plain array model of both weight matrices.
module tb_weight_server;

  localparam int NN  = 128;
  localparam int IMG = 784;
  localparam int OS  = 10;
  localparam int AW  = $clog2(IMG);

  typedef logic [NN-1:0][31:0] row0_t;
  typedef logic [OS-1:0][31:0] row1_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] delta;
    logic [31:0] exp_v;
  } sat_vec_t;

  logic          clk;
  logic          rst;
  logic          get_weights0, get_weights1, update0, update1;
  row0_t         wchange0;
  row1_t         wchange1;
  logic          init_we, init_layer;
  logic [AW-1:0] init_addr;
  row0_t         init_data;
  row0_t         weights0;
  row1_t         weights1;
  logic          w0_valid, w1_valid, busy;

  weight_server #(.NUM_NEURONS(NN), .IMG_SZ(IMG), .OUTPUT_SZ(OS)) dut (
    .clk(clk), .rst(rst),
    .get_weights0(get_weights0), .get_weights1(get_weights1),
    .update0(update0), .update1(update1),
    .wchange0(wchange0), .wchange1(wchange1),
    .init_we(init_we), .init_layer(init_layer), .init_addr(init_addr), .init_data(init_data),
    .weights0(weights0), .weights1(weights1),
    .w0_valid(w0_valid), .w1_valid(w1_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the two matrices.
  row0_t    m0 [IMG];
  row1_t    m1 [NN];
  sat_vec_t sat_tbl [OS];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] msat(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647)  return 32'h7fff_ffff;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return 32'(s);
  endfunction

  function automatic logic [31:0] rand_delta();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 65535)) - 32'd32768;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_row0(input string name, input int row, input row0_t act, input row0_t exp);
    int j;
    checks++;
    if (act !== exp) begin
      errors++;
      j = 0;
      while (j < NN - 1 && act[j] === exp[j]) j++;
      $display("FAIL %s row %0d lane %0d: got %h expected %h", name, row, j, act[j], exp[j]);
    end
  endtask

  task automatic chk_row1(input string name, input int row, input row1_t act, input row1_t exp);
    int j;
    checks++;
    if (act !== exp) begin
      errors++;
      j = 0;
      while (j < OS - 1 && act[j] === exp[j]) j++;
      $display("FAIL %s row %0d lane %0d: got %h expected %h", name, row, j, act[j], exp[j]);
    end
  endtask

  task automatic init_row0(input int addr, input row0_t d);
    init_we = 1'b1; init_layer = 1'b0; init_addr = AW'(addr); init_data = d;
    tick();
    init_we = 1'b0;
    m0[addr] = d;
  endtask

  task automatic init_row1(input int addr, input row1_t d);
    init_we = 1'b1; init_layer = 1'b1; init_addr = AW'(addr);
    init_data = '0; init_data[OS-1:0] = d;
    tick();
    init_we = 1'b0;
    m1[addr] = d;
  endtask

  // Full layer-0 read: row k at T+1+k, then idle zeros.
  task automatic rd0_check(input string name);
    get_weights0 = 1'b1; tick(); get_weights0 = 1'b0;
    for (int k = 0; k < IMG; k++) begin
      chk({name, " valid"}, 32'(w0_valid), 32'd1);
      chk_row0(name, k, weights0, m0[k]);
      tick();
    end
    chk({name, " end valid"}, 32'(w0_valid), 32'd0);
    chk_row0({name, " idle"}, IMG, weights0, '0);
  endtask

  task automatic rd1_check(input string name);
    get_weights1 = 1'b1; tick(); get_weights1 = 1'b0;
    for (int k = 0; k < NN; k++) begin
      chk({name, " valid"}, 32'(w1_valid), 32'd1);
      chk_row1(name, k, weights1, m1[k]);
      tick();
    end
    chk({name, " end valid"}, 32'(w1_valid), 32'd0);
    chk_row1({name, " idle"}, NN, weights1, '0);
  endtask

  // Layer-0 update; optionally restart once when row restart_at is sampled.
  task automatic up0_run(input int restart_at, input logic use_const, input logic [31:0] cval);
    row0_t d;
    int    k;
    logic  restarted;
    k = 0; restarted = 1'b0;
    update0 = 1'b1; tick(); update0 = 1'b0;
    while (k < IMG) begin
      for (int j = 0; j < NN; j++) d[j] = use_const ? cval : rand_delta();
      wchange0 = d;
      for (int j = 0; j < NN; j++) m0[k][j] = msat(m0[k][j], d[j]);
      chk("up0 busy", 32'(busy), 32'd1);
      if (k == restart_at && !restarted) begin
        update0 = 1'b1; restarted = 1'b1; k = 0;
      end else begin
        k++;
      end
      tick();
      update0 = 1'b0;
    end
    wchange0 = '0;
    chk("up0 busy end", 32'(busy), 32'd0);
  endtask

  // Layer-1 update; sat_mode applies table deltas to row 3 only.
  task automatic up1_run(input logic sat_mode);
    row1_t d;
    update1 = 1'b1; tick(); update1 = 1'b0;
    for (int k = 0; k < NN; k++) begin
      for (int j = 0; j < OS; j++)
        d[j] = sat_mode ? ((k == 3) ? sat_tbl[j].delta : 32'd0) : rand_delta();
      wchange1 = d;
      for (int j = 0; j < OS; j++) m1[k][j] = msat(m1[k][j], d[j]);
      chk("up1 busy", 32'(busy), 32'd1);
      tick();
    end
    wchange1 = '0;
    chk("up1 busy end", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    row0_t r0;
    row1_t r1;

    sat_tbl[0] = '{32'h7fff_fff0, 32'h0000_0100, 32'h7fff_ffff};
    sat_tbl[1] = '{32'h8000_0010, 32'hffff_ff00, 32'h8000_0000};
    sat_tbl[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    sat_tbl[3] = '{32'h0000_0001, 32'hffff_ffff, 32'h0000_0000};
    sat_tbl[4] = '{32'h7fff_ffff, 32'h0000_0001, 32'h7fff_ffff};
    sat_tbl[5] = '{32'h8000_0000, 32'hffff_ffff, 32'h8000_0000};
    sat_tbl[6] = '{32'h4000_0000, 32'h4000_0000, 32'h7fff_ffff};
    sat_tbl[7] = '{32'hc000_0000, 32'hc000_0000, 32'h8000_0000};
    sat_tbl[8] = '{32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff};
    sat_tbl[9] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789};

    rst = 1'b0;
    get_weights0 = 1'b0; get_weights1 = 1'b0; update0 = 1'b0; update1 = 1'b0;
    wchange0 = '0; wchange1 = '0;
    init_we = 1'b0; init_layer = 1'b0; init_addr = '0; init_data = '0;
    #2 rst = 1'b1;
    tick(); tick();
    chk_row0("reset weights0", 0, weights0, '0);
    chk_row1("reset weights1", 0, weights1, '0);
    chk("reset w0_valid", 32'(w0_valid), 32'd0);
    chk("reset w1_valid", 32'(w1_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Basic reads: mem1[r][j] = r*16+j.
    for (int r = 0; r < NN; r++) begin
      for (int j = 0; j < OS; j++) r1[j] = 32'(r * 16 + j);
      init_row1(r, r1);
    end
    for (int j = 0; j < NN; j++) r0[j] = 32'h0001_0000;
    for (int r = 0; r < IMG; r++) init_row0(r, r0);
    rd1_check("basic rd1");

    // Constant update: 0x10000 + 0x8000 everywhere.
    up0_run(-1, 1'b1, 32'h0000_8000);
    rd0_check("const up0");

    // Saturation vectors on mem1 row 3.
    for (int j = 0; j < OS; j++) r1[j] = sat_tbl[j].base;
    init_row1(3, r1);
    up1_run(1'b1);
    get_weights1 = 1'b1; tick(); get_weights1 = 1'b0;
    repeat (3) tick();
    for (int j = 0; j < OS; j++) chk($sformatf("sat lane %0d", j), weights1[j], sat_tbl[j].exp_v);
    repeat (NN - 3) tick();
    chk("sat rd1 end valid", 32'(w1_valid), 32'd0);

    // Concurrent update1 and get_weights0.
    get_weights0 = 1'b1; update1 = 1'b1; tick(); get_weights0 = 1'b0; update1 = 1'b0;
    for (int c = 0; c < IMG; c++) begin
      chk("conc w0_valid", 32'(w0_valid), 32'd1);
      chk_row0("conc rd0", c, weights0, m0[c]);
      chk("conc busy", 32'(busy), 32'd1);
      if (c < NN) begin
        for (int j = 0; j < OS; j++) r1[j] = rand_delta();
        wchange1 = r1;
        for (int j = 0; j < OS; j++) m1[c][j] = msat(m1[c][j], r1[j]);
      end else begin
        wchange1 = '0;
      end
      tick();
    end
    chk("conc busy end", 32'(busy), 32'd0);
    chk("conc w0_valid end", 32'(w0_valid), 32'd0);
    rd1_check("conc rd1");

    // Restart at row 100 with a dropped init write while busy.
    get_weights0 = 1'b1; tick(); get_weights0 = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      chk_row0("restart pre", k, weights0, m0[k]);
      init_we = (k == 50); init_layer = 1'b0; init_addr = AW'(5); init_data = ~m0[5];
      get_weights0 = (k == 100);
      tick();
    end
    get_weights0 = 1'b0; init_we = 1'b0;
    for (int k = 0; k < IMG; k++) begin
      chk_row0("restart post", k, weights0, m0[k]);
      tick();
    end
    chk("restart end valid", 32'(w0_valid), 32'd0);

    // Out-of-range layer-1 init must not alias onto a real row.
    init_we = 1'b1; init_layer = 1'b1; init_addr = AW'(200);
    for (int j = 0; j < NN; j++) init_data[j] = $urandom;
    tick();
    init_we = 1'b0;
    rd1_check("oor init rd1");

    // Reset abort in the middle of a read stream.
    get_weights0 = 1'b1; tick(); get_weights0 = 1'b0;
    repeat (50) tick();
    #2 rst = 1'b1;
    #1;
    chk_row0("abort weights0", 0, weights0, '0);
    chk("abort w0_valid", 32'(w0_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rd0_check("after abort rd0");

    // Update restarts: immediate (forwarding on row 0) and mid-stream.
    up0_run(0, 1'b0, 32'd0);
    rd0_check("fwd rd0");
    up0_run(300, 1'b0, 32'd0);
    rd0_check("mid restart rd0");

    // Random layer-1 rounds.
    for (int n = 0; n < 2; n++) begin
      up1_run(1'b0);
      rd1_check("rand rd1");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_server.md
# weight_server

Weight store and streaming responder for the MLP training tile. It answers the tile's `get_weights0`/`get_weights1` requests by streaming one weight row per cycle. It answers `update0`/`update1` by accepting one weight-change row per cycle and adding it, with saturation, into the stored weights. The block sits between the tile and the host/init path and holds both layer matrices in inferred synchronous RAM.

## Interface
- `NUM_NEURONS`, default 128: hidden-layer width. Layer-0 row width and layer-1 row count.
- `IMG_SZ`, default 784: layer-0 row count (input pixels).
- `OUTPUT_SZ`, default 10: layer-1 row width.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `get_weights0` input, 1 bit: 1-cycle pulse that starts a layer-0 read stream.
- `get_weights1` input, 1 bit: 1-cycle pulse that starts a layer-1 read stream.
- `update0` input, 1 bit: 1-cycle pulse that starts a layer-0 update stream.
- `update1` input, 1 bit: 1-cycle pulse that starts a layer-1 update stream.
- `wchange0` input, [NUM_NEURONS][32]: layer-0 delta row, signed fixed point.
- `wchange1` input, [OUTPUT_SZ][32]: layer-1 delta row, signed fixed point.
- `init_we` input, 1 bit: host row write strobe.
- `init_layer` input, 1 bit: host write target; 0 selects layer 0, 1 selects layer 1.
- `init_addr` input, $clog2(IMG_SZ) bits: host row index.
- `init_data` input, [NUM_NEURONS][32]: host row data. Layer 1 uses lanes 0..OUTPUT_SZ-1.
- `weights0` output, [NUM_NEURONS][32]: current layer-0 row.
- `weights1` output, [OUTPUT_SZ][32]: current layer-1 row.
- `w0_valid` output, 1 bit: `weights0` holds a stored row.
- `w1_valid` output, 1 bit: `weights1` holds a stored row.
- `busy` output, 1 bit: any stream is active.

## Operation
- Storage:
  - `mem0` has IMG_SZ rows × NUM_NEURONS lanes.
  - `mem1` has NUM_NEURONS rows × OUTPUT_SZ lanes.
  - Both use 1-cycle synchronous read. RAM contents are not reset and stay undefined until the host writes them.
- The block runs four independent streams: RD0, RD1, UP0 and UP1. Each stream has an FSM with states IDLE and ACTIVE and its own row counter.
- Read streams:
  - A `get_weightsN` pulse moves RDN to ACTIVE with counter 0.
  - Each ACTIVE cycle presents row k on `weightsN` with `wN_valid`=1, then increments k.
  - After the last row (IMG_SZ-1 for layer 0, NUM_NEURONS-1 for layer 1), RDN returns to IDLE.
  - While RDN is IDLE, `weightsN` is driven to 0 and `wN_valid`=0. This makes an extra consumer accumulate cycle harmless.
- Update streams:
  - An `updateN` pulse moves UPN to ACTIVE with counter 0.
  - Each ACTIVE cycle samples `wchangeN` as the delta for row k. The row is updated lane-wise as mem[k] = sat32(mem[k] + wchange[lane]).
  - sat32 is a signed 32-bit saturating add: results clamp to 0x7FFFFFFF or 0x80000000.
  - The row count per update stream is the same as the read stream for that layer.
  - The read-modify-write is pipelined: read row k one cycle ahead, add and write in the delta cycle. Throughput is one row per cycle with no stalls.
- Restart and overlap:
  - A new pulse on a stream that is already ACTIVE restarts that stream at row 0, and the old stream is abandoned.
  - Pulses on different streams may coincide and run concurrently.
- Same-layer read and update overlap:
  - A read of row k returns the RAM contents at the start of the read cycle. A write landing in the same cycle does not forward into that read.
  - An update RMW that targets a row written by the preceding update cycle must use the new value (internal forwarding).
- Host init:
  - `init_we` writes `init_data` to `init_addr` of the selected layer only when `busy`=0. Otherwise the write is silently dropped.
  - An out-of-range `init_addr` is dropped.
- `busy` = OR of all four stream ACTIVE states.

## Timing
- Reset, asynchronous and immediate: all streams go to IDLE, all counters go to 0, `weights0`/`weights1` = 0, `w0_valid`/`w1_valid`/`busy` = 0. Reset mid-stream aborts the stream. RAM keeps its contents, but a partially updated RMW row may hold the old or the new value.
- Read latency:
  - A pulse at cycle T puts row 0 on the outputs at T+1 and row k at T+1+k.
  - RD0 ends with row IMG_SZ-1 at T+IMG_SZ; `w0_valid` is 0 from T+IMG_SZ+1.
  - RD1 ends with row NUM_NEURONS-1 at T+NUM_NEURONS.
- Update latency:
  - A pulse at T means `wchangeN` is sampled at T+1+k for row k.
  - Row k is visible to a read issued at T+2+k or later.
  - `busy` is 1 from T+1 through the last delta cycle.
- Init: a host write at cycle T is readable by a stream started at T+1 or later.

## Test plan
- Basic reads:
  - Stimulus: init `mem1` row r, lane j = r*16+j. Pulse `get_weights1` at T.
  - Required: at T+1+r, `weights1`[j] = r*16+j for all r, j. `w1_valid` is high for exactly NUM_NEURONS cycles, then `weights1` = 0.
- Update:
  - Stimulus: init `mem0` to all 0x00010000. Pulse `update0`. Drive `wchange0` = 0x00008000 on every row.
  - Required: a later `get_weights0` returns 0x00018000 in every lane of every row.
- Saturation:
  - Stimulus: `mem1` row 3 lane 0 = 0x7FFFFFF0 with delta 0x100; lane 1 = 0x80000010 with delta 0xFFFFFF00.
  - Required: lane 0 reads 0x7FFFFFFF and lane 1 reads 0x80000000.
- Concurrency:
  - Stimulus: pulse `update1` and `get_weights0` in the same cycle.
  - Required: both complete with the correct timing and data, and `busy` falls only after the longer stream ends.
- Restart and init blocking:
  - Stimulus: pulse `get_weights0` again at row 100. Also assert `init_we` while `busy`=1.
  - Required: the stream restarts at row 0 on the next cycle, and the dropped init write leaves the target row unchanged.
- Reset abort:
  - Stimulus: assert `rst` mid RD0.
  - Required: outputs go to 0 and `w0_valid`=0 immediately. After reset releases, a new `get_weights0` returns row 0 first.
